// File: rtl/t_flop_bank.sv
// Purpose : WIDTH-bit bank of T flip-flops with four modes: independent toggle, up count, down count, hold.
// Latency : every output is registered and updates one clk edge after its inputs are sampled.
// Backpressure: none; the bank accepts new inputs on every edge.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   enable, mode, T   - global enable, mode (00 indep, 01 up, 10 down, 11 hold) and toggle inputs
//   load, D           - parallel-load strobe and data (load beats enable)
//   Q, Qbar           - state and its complement
//   tc, toggled       - registered wrap pulse and registered mask of bits toggled on the last edge
//   toggle_cnt        - saturating toggle-event count, present when TFF_TOGGLE_CNT_EN is defined,
//                       otherwise tied to zero (the port exists in both builds)
module t_flop_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] T,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             tc,
  output logic [WIDTH-1:0] toggled,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [1:0] MODE_INDEP = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] toggled_q, toggled_d;
  logic [WIDTH-1:0] mask;
  logic             wrap;
  logic             carry;

  // Toggle mask for the current mode. In the counting modes a bit toggles when
  // T[0] is set and every lower bit is at its "carry" value (1 for up, 0 for down),
  // built as a running AND so no variable-width slice is needed.
  always_comb begin
    mask  = '0;
    wrap  = 1'b0;
    carry = 1'b0;
    case (mode)
      MODE_INDEP: mask = T;
      MODE_UP: begin
        carry = T[0];
        for (int i = 0; i < WIDTH; i++) begin
          mask[i] = carry;
          carry   = carry & q_q[i];
        end
        wrap = carry;  // T[0] and Q all-ones
      end
      MODE_DOWN: begin
        carry = T[0];
        for (int i = 0; i < WIDTH; i++) begin
          mask[i] = carry;
          carry   = carry & ~q_q[i];
        end
        wrap = carry;  // T[0] and Q all-zeros
      end
      default: mask = '0;
    endcase
  end

  // Priority: load over enable (reset is applied in the register block).
  always_comb begin
    q_d       = q_q;
    tc_d      = 1'b0;
    toggled_d = '0;
    if (load) begin
      q_d = D;
    end else if (enable) begin
      q_d       = q_q ^ mask;
      tc_d      = wrap;
      toggled_d = mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RESET_VAL;
      tc_q      <= 1'b0;
      toggled_q <= '0;
    end else begin
      q_q       <= q_d;
      tc_q      <= tc_d;
      toggled_q <= toggled_d;
    end
  end

`ifdef TFF_TOGGLE_CNT_EN
  logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;

  // Counts edges with a non-zero mask; saturates instead of wrapping. Load leaves it alone.
  always_comb begin
    toggle_cnt_d = toggle_cnt_q;
    if (!load && enable && (|mask) && (toggle_cnt_q != {CNT_W{1'b1}})) begin
      toggle_cnt_d = toggle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_cnt_q <= '0;
    end else begin
      toggle_cnt_q <= toggle_cnt_d;
    end
  end

  assign toggle_cnt = toggle_cnt_q;
`else
  assign toggle_cnt = '0;
`endif

  assign Q       = q_q;
  assign Qbar    = ~q_q;  // same register as Q, so never out of step
  assign tc      = tc_q;
  assign toggled = toggled_q;

endmodule

// File: doc/t_flop_bank.md
Name: t_flop_bank

Overview:
- Parametrised successor to the single T latch.
- WIDTH edge-triggered T flip-flops share one clock, synchronous reset, parallel load and a global enable.
- A mode select chooses one of four behaviours for the bank:
  - independent per-bit toggle;
  - cascaded synchronous up-counter;
  - cascaded synchronous down-counter;
  - hold.
- Used as a toggle-register bank or a small counter/divider building block in later days' designs.

Parameters:
- WIDTH, 4, number of T flip-flops (bits); legal range 2..32.
- RESET_VAL, 0, WIDTH-bit value loaded into Q on reset.
- CNT_W, 8, width of the optional toggle-event counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  global toggle enable.
- mode  input  2  mode select: 00 independent, 01 count up, 10 count down, 11 hold.
- T  input  WIDTH  per-bit toggle inputs. Mode 00 uses all bits. Modes 01/10 use T[0] as count enable and ignore T[WIDTH-1:1].
- load  input  1  parallel-load strobe.
- D  input  WIDTH  parallel-load data.
- Q  output  WIDTH  flip-flop state.
- Qbar  output  WIDTH  bitwise complement of Q.
- tc  output  1  terminal-count pulse, registered.
- toggled  output  WIDTH  registered mask of the bits that toggled on the previous edge.
- toggle_cnt  output  CNT_W  toggle-event count; feature-dependent, see Optional Feature.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - Q = RESET_VAL, Qbar = ~RESET_VAL;
  - tc = 0, toggled = 0, toggle_cnt = 0.
- Priority per edge: rst > load > enable.
- Reset mid-operation overrides any load or count on that edge. No partial update occurs.
- load=1: Q <= D; tc <= 0; toggled <= 0. This holds regardless of enable and mode. A load is not a toggle event.
- enable=0 (no load): Q holds; tc <= 0; toggled <= 0.
- enable=1, mode 00: toggle mask m = T. Q <= Q ^ m.
- enable=1, mode 01:
  - m[0] = T[0]; m[i] = T[0] & (&Q[i-1:0]).
  - Q <= Q ^ m, i.e. Q+1 modulo 2^WIDTH.
- enable=1, mode 10:
  - m[0] = T[0]; m[i] = T[0] & (&~Q[i-1:0]).
  - Q <= Q ^ m, i.e. Q-1 modulo 2^WIDTH.
- enable=1, mode 11: m = 0. Q holds.
- toggled <= m on every non-reset, non-load edge.
- tc:
  - Set to 1 for exactly one cycle after an edge on which the counter wraps.
  - Wrap in mode 01: Q was all-ones and T[0]=1.
  - Wrap in mode 10: Q was zero and T[0]=1.
  - Otherwise tc is 0. Mode 00 never raises tc, even if Q passes through all-ones or zero.
- Qbar:
  - Always exactly ~Q. It is derived from the same state register, so there is never a cycle where Qbar != ~Q.
- Latency: all outputs change one clock edge after the inputs are sampled. There is no combinational input-to-output path.
- Mode change mid-count: takes effect on the next edge. The current Q is the starting point and no reset is implied.
- Width rule: the cascade mask uses only lower bits. Bit 0 toggles whenever T[0]=1 in modes 01/10.

Optional Feature:
- Macro: TFF_TOGGLE_CNT_EN.
- Defined:
  - toggle_cnt increments by 1 on each non-reset, non-load edge where m != 0.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It clears only on rst. Load does not clear it.
- Undefined:
  - Counter logic is removed and toggle_cnt is tied to 0.
  - The port remains, so the interface is identical in both builds.

Test Plan (WIDTH=4, RESET_VAL=0):
- Reset and hold:
  - rst=1 for 1 edge with load=1, D=4'hF -> Q=0, Qbar=4'hF, tc=0, toggled=0.
  - Then enable=0, T=4'hF for 3 edges -> Q stays 0.
- Independent toggle:
  - mode=00, enable=1, T=4'b0101 for 2 edges -> Q=5 then 0, toggled=5 both cycles, tc=0.
  - Then enable=0 -> toggled=0.
- Up count with wrap:
  - load D=4'hE, then mode=01, enable=1, T[0]=1 -> Q=F, then 0 with tc=1 for exactly one cycle, then 1 with tc=0.
  - toggled on the wrap edge = 4'hF.
- Down count with wrap:
  - load D=1, mode=10, T[0]=1 -> Q=0, then F with tc=1 one cycle, then E.
  - T[0]=0 for 2 edges -> Q holds E, T[3:1] ignored.
- Priority and mid-operation reset:
  - During up count at Q=7, assert load=1 with D=3 and enable=1 -> Q=3, tc=0.
  - Next edge assert rst=1 and load=1 -> Q=0, toggle_cnt=0.
- Toggle counter (TFF_TOGGLE_CNT_EN, CNT_W=2):
  - mode=00, T=1 for 5 edges -> toggle_cnt 1,2,3,3,3 (saturates).
  - Intervening load does not change toggle_cnt.
  - Without the macro -> toggle_cnt=0 throughout.
